dram_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single DRAM port (one read address, one write address, one read-data return) between NUM_REQ layer engines (conv, relu, pool, later fc).
- Lets engines request DRAM concurrently instead of relying on strict top-level time-multiplexing.
- Tracks at most one outstanding read and routes returned data to its owner.
- Flags a read that receives no dram_valid within TIMEOUT cycles.

---
 rtl/dram_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter that shares one DRAM port among NUM_REQ engines.
// It tracks at most one outstanding read and returns an error response when that read times out.
module dram_port_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 18,
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned TIMEOUT    = 256
) (
   input  logic                          clk,
   input  logic                          srst,
   input  logic [NUM_REQ-1:0]            req_rd,
   input  logic [NUM_REQ-1:0]            req_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [NUM_REQ-1:0]            rsp_err,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          dram_valid,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic [ADDR_WIDTH-1:0]         addr_in,
   output logic [ADDR_WIDTH-1:0]         addr_out,
   output logic                          dram_en_rd,
   output logic                          dram_en_wr,
   output logic                          busy
);

   localparam int unsigned    IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned    CW       = $clog2(TIMEOUT);
   localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_REQ - 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE_WR = 2'd1,
      ISSUE_RD = 2'd2,
      RD_WAIT  = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [IW-1:0]         r_ptr, w_ptr_nxt;
   logic [IW-1:0]         r_win, w_win_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;

   logic [NUM_REQ-1:0]    w_pend;
   logic                  w_found_hi, w_found_lo, w_found;
   logic [IW-1:0]         w_win_hi, w_win_lo, w_win;
   logic [NUM_REQ-1:0]    w_win_oh, w_own_oh;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic                  w_sel_wr;

   logic [NUM_REQ-1:0]    w_gnt_nxt, w_rsp_valid_nxt, w_rsp_err_nxt;
   logic [DATA_WIDTH-1:0] w_rsp_data_nxt, w_data_out_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_in_nxt, w_addr_out_nxt;
   logic                  w_en_rd_nxt, w_en_wr_nxt;

   // Rotating priority: first pending index at or above ptr, otherwise wrap to the lowest pending index.
   always_comb begin
      w_pend     = req_rd | req_wr;
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      w_win_hi   = '0;
      w_win_lo   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (w_pend[k] && !w_found_lo) begin
            w_found_lo = 1'b1;
            w_win_lo   = IW'(k);
         end
         if (w_pend[k] && (IW'(k) >= r_ptr) && !w_found_hi) begin
            w_found_hi = 1'b1;
            w_win_hi   = IW'(k);
         end
      end
      w_found = w_found_hi | w_found_lo;
      w_win   = w_found_hi ? w_win_hi : w_win_lo;

      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_wr    = 1'b0;
      w_win_oh    = '0;
      w_own_oh    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (IW'(k) == w_win) begin
            w_sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            w_sel_wr    = req_wr[k];
            w_win_oh[k] = 1'b1;
         end
         w_own_oh[k] = (IW'(k) == r_win);
      end
   end

   // Output values are computed on the transition, so the registered strobes coincide with the ISSUE_* state.
   always_comb begin
      w_state_nxt     = r_state;
      w_ptr_nxt       = r_ptr;
      w_win_nxt       = r_win;
      w_cnt_nxt       = r_cnt;
      w_gnt_nxt       = '0;
      w_en_wr_nxt     = 1'b0;
      w_en_rd_nxt     = 1'b0;
      w_addr_in_nxt   = '0;
      w_addr_out_nxt  = '0;
      w_data_out_nxt  = '0;
      w_rsp_valid_nxt = '0;
      w_rsp_err_nxt   = '0;
      w_rsp_data_nxt  = '0;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               w_win_nxt = w_win;
               w_ptr_nxt = (w_win == IDX_LAST) ? '0 : w_win + 1'b1;
               w_gnt_nxt = w_win_oh;
               if (w_sel_wr) begin
                  w_state_nxt    = ISSUE_WR;
                  w_en_wr_nxt    = 1'b1;
                  w_addr_out_nxt = w_sel_addr;
                  w_data_out_nxt = w_sel_wdata;
               end else begin
                  w_state_nxt   = ISSUE_RD;
                  w_en_rd_nxt   = 1'b1;
                  w_addr_in_nxt = w_sel_addr;
               end
            end
         end
         ISSUE_WR: w_state_nxt = IDLE;
         ISSUE_RD: begin
            w_state_nxt = RD_WAIT;
            w_cnt_nxt   = '0;
         end
         RD_WAIT: begin
            if (dram_valid) begin
               w_state_nxt     = IDLE;
               w_rsp_valid_nxt = w_own_oh;
               w_rsp_data_nxt  = data_in;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt     = IDLE;
               w_rsp_valid_nxt = w_own_oh;
               w_rsp_err_nxt   = w_own_oh;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_win      <= '0;
         r_cnt      <= '0;
         gnt        <= '0;
         rsp_valid  <= '0;
         rsp_err    <= '0;
         rsp_data   <= '0;
         data_out   <= '0;
         addr_in    <= '0;
         addr_out   <= '0;
         dram_en_rd <= 1'b0;
         dram_en_wr <= 1'b0;
         busy       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_win      <= w_win_nxt;
         r_cnt      <= w_cnt_nxt;
         gnt        <= w_gnt_nxt;
         rsp_valid  <= w_rsp_valid_nxt;
         rsp_err    <= w_rsp_err_nxt;
         rsp_data   <= w_rsp_data_nxt;
         data_out   <= w_data_out_nxt;
         addr_in    <= w_addr_in_nxt;
         addr_out   <= w_addr_out_nxt;
         dram_en_rd <= w_en_rd_nxt;
         dram_en_wr <= w_en_wr_nxt;
         busy       <= (w_state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: a transaction-level round-robin model predicts grants and responses.
// A negedge monitor pops the expected grants and responses and compares them with the DUT outputs.
module tb_dram_port_arbiter;

   localparam int NR = 3;
   localparam int AW = 18;
   localparam int DW = 32;
   localparam int TO = 8;

   logic              clk;
   logic              srst;
   logic [NR-1:0]     req_rd, req_wr;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     gnt, rsp_valid, rsp_err;
   logic [DW-1:0]     rsp_data, data_in, data_out;
   logic              dram_valid;
   logic [AW-1:0]     addr_in, addr_out;
   logic              dram_en_rd, dram_en_wr, busy;

   dram_port_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REQ    (NR),
      .TIMEOUT    (TO)
   ) dut (
      .clk        (clk),
      .srst       (srst),
      .req_rd     (req_rd),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_err    (rsp_err),
      .rsp_data   (rsp_data),
      .data_in    (data_in),
      .dram_valid (dram_valid),
      .data_out   (data_out),
      .addr_in    (addr_in),
      .addr_out   (addr_out),
      .dram_en_rd (dram_en_rd),
      .dram_en_wr (dram_en_wr),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int idx; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } gnt_t;
   typedef struct { int idx; bit err; logic [DW-1:0] data; int lat; } rsp_t;
   typedef struct { int d; logic [DW-1:0] data; } plan_t;

   gnt_t  exp_gnt[$];
   rsp_t  exp_rsp[$];
   plan_t plan[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int issue_cyc = 0;
   int wd      = 0;
   logic srst_q = 1'b0;

   int mdl_ptr;
   int rd_cnt;
   logic [DW-1:0] rd_data;
   bit rd_busy, late_valid;

   function automatic logic [NR-1:0] onehot(input int i);
      logic [NR-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) srst_q <= srst;

   // Monitor: compares DUT outputs with the scoreboard on the falling edge.
   gnt_t m_g;
   rsp_t m_r;
   always @(negedge clk) begin
      bit popped;
      popped = 1'b0;
      cyc++;
      if (srst_q) begin
         chk("reset_outputs", {gnt, rsp_valid, rsp_err, rsp_data, data_out, addr_in, addr_out,
                               dram_en_rd, dram_en_wr, busy}, '0);
      end else begin
         if (gnt != '0) begin
            if (exp_gnt.size() == 0) begin
               chk("gnt_unexpected", gnt, '0);
            end else begin
               m_g = exp_gnt.pop_front();
               popped = 1'b1;
               chk("gnt_onehot", gnt, onehot(m_g.idx));
               chk("gnt_busy", busy, 1);
               chk("en_wr", dram_en_wr, m_g.wr);
               chk("en_rd", dram_en_rd, !m_g.wr);
               if (m_g.wr) begin
                  chk("wr_addr_out", addr_out, m_g.addr);
                  chk("wr_data_out", data_out, m_g.wdata);
                  chk("wr_addr_in_zero", addr_in, '0);
               end else begin
                  chk("rd_addr_in", addr_in, m_g.addr);
                  chk("rd_addr_out_zero", {addr_out, data_out}, '0);
                  issue_cyc = cyc;
               end
            end
         end else begin
            chk("idle_port_zero", {dram_en_rd, dram_en_wr, addr_in, addr_out, data_out}, '0);
         end
         if (rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, '0);
            end else begin
               m_r = exp_rsp.pop_front();
               popped = 1'b1;
               chk("rsp_valid", rsp_valid, onehot(m_r.idx));
               chk("rsp_err", rsp_err, m_r.err ? onehot(m_r.idx) : '0);
               chk("rsp_data", rsp_data, m_r.data);
               chk("rsp_latency", cyc - issue_cyc, m_r.lat);
               chk("rsp_busy", busy, 0);
            end
         end else begin
            chk("no_rsp_zero", {rsp_err, rsp_data}, '0);
         end
      end
      if (popped || (exp_gnt.size() == 0 && exp_rsp.size() == 0)) wd = 0;
      else wd++;
      if (wd > 4*TO + 20) begin
         n_tests++;
         n_fail++;
         $display("FAIL watchdog: no expected grant/response for %0d cycles, %0d gnt and %0d rsp outstanding",
                  wd, exp_gnt.size(), exp_rsp.size());
         exp_gnt.delete();
         exp_rsp.delete();
         wd = 0;
      end
   end

   // One clock of stimulus: requester agents react to gnt, DRAM model replays its latency plan.
   task automatic step();
      plan_t p;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (gnt[i]) begin
            if (req_wr[i]) req_wr[i] = 1'b0;
            else           req_rd[i] = 1'b0;
         end
      end
      if (rsp_valid != '0) rd_busy = 1'b0;
      dram_valid = 1'b0;
      data_in    = $urandom();
      if (late_valid) begin
         dram_valid = 1'b1;
         late_valid = 1'b0;
      end else if (dram_en_rd) begin
         if (plan.size() > 0) p = plan.pop_front();
         else p = '{d: 0, data: '0};
         rd_cnt     = (p.d <= TO) ? p.d : 0;
         rd_data    = p.data;
         rd_busy    = 1'b1;
         dram_valid = 1'($urandom_range(0, 1));
      end else if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            dram_valid = 1'b1;
            data_in    = rd_data;
         end
      end else if (!rd_busy) begin
         dram_valid = ($urandom_range(0, 7) == 0);
      end
   endtask

   // Reference model: resolve a batch of simultaneous requests into the round-robin grant sequence.
   task automatic load_batch(input logic [NR-1:0] rd, input logic [NR-1:0] wr,
                             input int force_d, input bit no_rsp);
      logic [AW-1:0] a[NR];
      logic [DW-1:0] w[NR];
      logic [NR-1:0] prd, pwr;
      int ptr, win, d;
      bit found;
      logic [DW-1:0] dd;
      for (int i = 0; i < NR; i++) begin
         a[i] = AW'($urandom());
         w[i] = $urandom();
      end
      prd = rd;
      pwr = wr;
      ptr = mdl_ptr;
      while ((prd | pwr) != '0) begin
         found = 1'b0;
         win   = 0;
         for (int k = 0; k < NR; k++) begin
            if (!found && (prd[(ptr + k) % NR] || pwr[(ptr + k) % NR])) begin
               found = 1'b1;
               win   = (ptr + k) % NR;
            end
         end
         if (pwr[win]) begin
            exp_gnt.push_back('{idx: win, wr: 1'b1, addr: a[win], wdata: w[win]});
            pwr[win] = 1'b0;
         end else begin
            exp_gnt.push_back('{idx: win, wr: 1'b0, addr: a[win], wdata: '0});
            prd[win] = 1'b0;
            d  = (force_d > 0) ? force_d : $urandom_range(1, TO + 2);
            dd = $urandom();
            plan.push_back('{d: d, data: dd});
            if (!no_rsp) begin
               if (d > TO) exp_rsp.push_back('{idx: win, err: 1'b1, data: '0, lat: TO + 1});
               else        exp_rsp.push_back('{idx: win, err: 1'b0, data: dd, lat: d + 1});
            end
         end
         ptr = (win + 1) % NR;
      end
      mdl_ptr = ptr;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW]  = a[i];
         req_wdata[i*DW +: DW] = w[i];
      end
      req_rd = rd;
      req_wr = wr;
   endtask

   task automatic drain();
      for (int g = 0; g < 3000 && (exp_gnt.size() != 0 || exp_rsp.size() != 0); g++) step();
      if (exp_gnt.size() != 0 || exp_rsp.size() != 0) begin
         $display("FAIL drain: scoreboard still holds %0d gnt and %0d rsp entries", exp_gnt.size(), exp_rsp.size());
         $fatal(1, "drain bound expired");
      end
      step();
   endtask

   initial begin
      srst       = 1'b1;
      req_rd     = '0;
      req_wr     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      dram_valid = 1'b0;
      data_in    = '0;
      late_valid = 1'b0;
      rd_busy    = 1'b0;
      rd_cnt     = 0;
      rd_data    = '0;
      mdl_ptr    = 0;
      repeat (3) step();
      srst = 1'b0;
      step();

      load_batch(3'b000, 3'b010, 0, 1'b0); drain();       // single write
      load_batch(3'b000, 3'b111, 0, 1'b0); drain();       // round robin from ptr 2
      load_batch(3'b100, 3'b000, 3, 1'b0); drain();       // read, data after 3 cycles
      load_batch(3'b001, 3'b000, TO + 1, 1'b0); drain();  // timeout
      load_batch(3'b001, 3'b000, TO, 1'b0); drain();      // data on final count wins
      load_batch(3'b001, 3'b000, 1, 1'b0); drain();       // minimum latency
      load_batch(3'b010, 3'b010, 0, 1'b0); drain();       // write before read, same requester

      repeat (40) begin
         load_batch(NR'($urandom()), NR'($urandom()), 0, 1'b0);
         drain();
      end

      // Reset while a read waits for DRAM: the read is dropped and ptr returns to 0.
      load_batch(onehot($urandom_range(0, NR - 1)), '0, TO + 1, 1'b1);
      for (int g = 0; g < 20 && !rd_busy; g++) step();
      step();
      step();
      srst   = 1'b1;
      req_rd = '0;
      req_wr = '0;
      rd_busy = 1'b0;
      rd_cnt  = 0;
      plan.delete();
      step();
      step();
      srst       = 1'b0;
      late_valid = 1'b1;
      repeat (6) step();
      mdl_ptr = 0;
      load_batch(3'b000, 3'b111, 0, 1'b0); drain();
      load_batch(3'b111, 3'b000, 0, 1'b0); drain();

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
